// File: rtl/secded_pipe_decoder_pkg.sv
// Shared helpers for the parametrised SECDED decoder: parity-width sizing,
// codeword layout queries, data-field extraction and the error classification.
package secded_pkg;

    localparam int unsigned MAX_CW = 256;

    typedef enum logic [1:0] {
        CLEAN,
        CORR,
        UNCORR
    } err_class_e;

    function automatic int unsigned calc_p(input int unsigned data_w);
        int unsigned p;
        p = 1;
        while ((32'd1 << p) < (data_w + p + 1)) p++;
        return p;
    endfunction

    function automatic logic is_pow2(input int unsigned idx);
        return (idx != 0) && ((idx & (idx - 1)) == 0);
    endfunction

    // Data occupies every non-power-of-two position above bit 0, in ascending order.
    function automatic logic [MAX_CW-1:0] extract_data(input logic [MAX_CW-1:0] code,
                                                       input int unsigned       cw);
        logic [MAX_CW-1:0] d;
        logic [MAX_CW-1:0] sh;
        int unsigned       j;
        d  = '0;
        sh = code;
        j  = 0;
        for (int unsigned i = 0; i < MAX_CW; i++) begin
            if ((i != 0) && (i < cw) && !is_pow2(i)) begin
                d = d | (MAX_CW'(sh[0]) << j);
                j++;
            end
            sh = sh >> 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/secded_pipe_decoder_syndrome_calc.sv
// Combinational Hamming syndrome and overall-parity check for one codeword.
module secded_syndrome_calc
    import secded_pkg::*;
#(
    parameter int unsigned CW = 13,
    parameter int unsigned P  = 4
) (
    input  logic [CW-1:0] i_code,
    output logic [P-1:0]  o_syndrome,
    output logic          o_pfail
);

    // The syndrome is the XOR of the positions of all set bits.
    always_comb begin
        logic [CW-1:0] w_sh;
        o_syndrome = '0;
        w_sh       = i_code;
        for (int unsigned i = 0; i < CW; i++) begin
            if (w_sh[0]) o_syndrome = o_syndrome ^ P'(i);
            w_sh = w_sh >> 1;
        end
    end

    assign o_pfail = ^i_code;

endmodule

// File: rtl/secded_pipe_decoder.sv
// Two-stage pipelined SECDED decoder on a valid/ready stream with saturating error counters.
// Optional first-uncorrectable-error log enabled by defining SECDED_ERR_LOG_EN.
module secded_pipe_decoder
    import secded_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned P      = calc_p(DATA_W),
    localparam int unsigned CW     = DATA_W + P + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_code,
    output logic [DATA_W-1:0] out_data,
    output logic [P-1:0]      out_syndrome,
    output logic              out_1bit_err,
    output logic              out_2bit_err,
`ifdef SECDED_ERR_LOG_EN
    output logic              err_log_valid,
    output logic [CW-1:0]     err_log_code,
    output logic [P-1:0]      err_log_syndrome,
`endif
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  cnt_1bit,
    output logic [CNT_W-1:0]  cnt_2bit
);

    logic              r_s1_valid;
    logic [CW-1:0]     r_s1_code;
    logic [P-1:0]      r_s1_syn;
    logic              r_s1_pfail;

    logic              r_out_valid;
    logic [CW-1:0]     r_out_code;
    logic [DATA_W-1:0] r_out_data;
    logic [P-1:0]      r_out_syn;
    logic              r_out_1bit;
    logic              r_out_2bit;

    logic [CNT_W-1:0]  r_cnt_1bit;
    logic [CNT_W-1:0]  r_cnt_2bit;

    logic [P-1:0]      w_syn;
    logic              w_pfail;
    logic              w_s2_ready;
    logic              w_in_ready;
    err_class_e        w_class;
    logic [CW-1:0]     w_corr;
    logic [DATA_W-1:0] w_data;
    logic              w_xfer;
    logic              w_inc_1bit;
    logic              w_inc_2bit;

    secded_syndrome_calc #(
        .CW (CW),
        .P  (P)
    ) u_syndrome (
        .i_code     (in_code),
        .o_syndrome (w_syn),
        .o_pfail    (w_pfail)
    );

    assign w_s2_ready = !r_out_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_ready;
    assign in_ready   = w_in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_syn   <= '0;
            r_s1_pfail <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_code  <= in_code;
                r_s1_syn   <= w_syn;
                r_s1_pfail <= w_pfail;
            end
        end
    end

    // A syndrome pointing past the top of the word cannot be a single flip.
    always_comb begin
        w_class = CLEAN;
        if (r_s1_pfail) begin
            w_class = (32'(r_s1_syn) < CW) ? CORR : UNCORR;
        end else if (r_s1_syn != '0) begin
            w_class = UNCORR;
        end
        w_corr = r_s1_code;
        if (w_class == CORR) w_corr = r_s1_code ^ (CW'(1) << r_s1_syn);
    end

    assign w_data = DATA_W'(extract_data(MAX_CW'(w_corr), CW));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_out_data  <= '0;
            r_out_syn   <= '0;
            r_out_1bit  <= 1'b0;
            r_out_2bit  <= 1'b0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_code <= w_corr;
                r_out_data <= w_data;
                r_out_syn  <= r_s1_syn;
                r_out_1bit <= (w_class == CORR);
                r_out_2bit <= (w_class == UNCORR);
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_code     = r_out_code;
    assign out_data     = r_out_data;
    assign out_syndrome = r_out_syn;
    assign out_1bit_err = r_out_1bit;
    assign out_2bit_err = r_out_2bit;

    assign w_xfer     = r_out_valid && out_ready;
    assign w_inc_1bit = w_xfer && r_out_1bit;
    assign w_inc_2bit = w_xfer && r_out_2bit;

    // A clear coinciding with a counted transfer keeps that transfer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt_1bit <= '0;
            r_cnt_2bit <= '0;
        end else begin
            if (cnt_clear) begin
                r_cnt_1bit <= w_inc_1bit ? CNT_W'(1) : '0;
            end else if (w_inc_1bit && (r_cnt_1bit != '1)) begin
                r_cnt_1bit <= r_cnt_1bit + CNT_W'(1);
            end
            if (cnt_clear) begin
                r_cnt_2bit <= w_inc_2bit ? CNT_W'(1) : '0;
            end else if (w_inc_2bit && (r_cnt_2bit != '1)) begin
                r_cnt_2bit <= r_cnt_2bit + CNT_W'(1);
            end
        end
    end

    assign cnt_1bit = r_cnt_1bit;
    assign cnt_2bit = r_cnt_2bit;

`ifdef SECDED_ERR_LOG_EN
    logic          r_log_valid;
    logic [CW-1:0] r_log_code;
    logic [P-1:0]  r_log_syn;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_log_valid <= 1'b0;
            r_log_code  <= '0;
            r_log_syn   <= '0;
        end else if (w_inc_2bit && (cnt_clear || !r_log_valid)) begin
            r_log_valid <= 1'b1;
            r_log_code  <= r_out_code;
            r_log_syn   <= r_out_syn;
        end else if (cnt_clear) begin
            r_log_valid <= 1'b0;
        end
    end

    assign err_log_valid    = r_log_valid;
    assign err_log_code     = r_log_code;
    assign err_log_syndrome = r_log_syn;
`endif

endmodule

// File: tb/tb_secded_pipe_decoder.sv
// Scoreboard bench for secded_pipe_decoder (DATA_W=8, CNT_W=2) with directed codewords.
module tb_secded_pipe_decoder;

    typedef struct {
        logic [12:0] code;
        logic [12:0] ecode;
        logic [7:0]  edata;
        logic [3:0]  esyn;
        logic        e1;
        logic        e2;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] in_code = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [12:0] out_code;
    logic [7:0]  out_data;
    logic [3:0]  out_syndrome;
    logic        out_1bit_err;
    logic        out_2bit_err;
    logic        cnt_clear = 1'b0;
    logic [1:0]  cnt_1bit;
    logic [1:0]  cnt_2bit;
`ifdef SECDED_ERR_LOG_EN
    logic        err_log_valid;
    logic [12:0] err_log_code;
    logic [3:0]  err_log_syndrome;
`endif

    vec_t vecs[9];
    vec_t sb[$];
    int   bp_seq[6] = '{5, 6, 7, 3, 0, 1};
    int   n_cmp = 0;
    int   n_bad = 0;

    secded_pipe_decoder #(
        .DATA_W (8),
        .CNT_W  (2)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_code          (in_code),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_code         (out_code),
        .out_data         (out_data),
        .out_syndrome     (out_syndrome),
        .out_1bit_err     (out_1bit_err),
        .out_2bit_err     (out_2bit_err),
`ifdef SECDED_ERR_LOG_EN
        .err_log_valid    (err_log_valid),
        .err_log_code     (err_log_code),
        .err_log_syndrome (err_log_syndrome),
`endif
        .cnt_clear        (cnt_clear),
        .cnt_1bit         (cnt_1bit),
        .cnt_2bit         (cnt_2bit)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic idle(input logic ordy);
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = ordy;
        cnt_clear = 1'b0;
    endtask

    task automatic send(input int idx, input logic ordy);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clock);
            in_valid  = 1'b1;
            in_code   = vecs[idx].code;
            out_ready = ordy;
            cnt_clear = 1'b0;
            #1;
            acc = in_ready;
        end
        if (acc) sb.push_back(vecs[idx]);
        else     fail_now("send_timeout");
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1'b1);
        if (sb.size() != 0) begin
            fail_now("drain_timeout");
            sb.delete();
        end
        idle(1'b1);
        #3;
    endtask

    // Monitor: compares the head of the scoreboard whenever a result is
    // presented, and pops it only on a transfer, so stalled outputs must hold.
    initial begin
        vec_t e;
        forever begin
            @(negedge clock);
            #2;
            if (!reset && out_valid) begin
                if (sb.size() == 0) begin
                    fail_now("spurious_output");
                end else begin
                    e = sb[0];
                    check("out_code",     32'(out_code),     32'(e.ecode));
                    check("out_data",     32'(out_data),     32'(e.edata));
                    check("out_syndrome", 32'(out_syndrome), 32'(e.esyn));
                    check("out_1bit_err", 32'(out_1bit_err), 32'(e.e1));
                    check("out_2bit_err", 32'(out_2bit_err), 32'(e.e2));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int lat;
        vecs[0] = '{13'h0000, 13'h0000, 8'h00, 4'h0, 1'b0, 1'b0};
        vecs[1] = '{13'h0020, 13'h0000, 8'h00, 4'h5, 1'b1, 1'b0};
        vecs[2] = '{13'h0001, 13'h0000, 8'h00, 4'h0, 1'b1, 1'b0};
        vecs[3] = '{13'h0028, 13'h0028, 8'h03, 4'h6, 1'b0, 1'b1};
        vecs[4] = '{13'h0112, 13'h0112, 8'h00, 4'hD, 1'b0, 1'b1};
        vecs[5] = '{13'h144E, 13'h144E, 8'hA5, 4'h0, 1'b0, 1'b0};
        vecs[6] = '{13'h104E, 13'h144E, 8'hA5, 4'hA, 1'b1, 1'b0};
        vecs[7] = '{13'h044E, 13'h144E, 8'hA5, 4'hC, 1'b1, 1'b0};
        vecs[8] = '{13'h144F, 13'h144E, 8'hA5, 4'h0, 1'b1, 1'b0};

        repeat (3) @(negedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid),    32'd0);
        check("rst_in_ready",  32'(in_ready),     32'd1);
        check("rst_out_code",  32'(out_code),     32'd0);
        check("rst_out_data",  32'(out_data),     32'd0);
        check("rst_out_syn",   32'(out_syndrome), 32'd0);
        check("rst_flags",     32'({out_1bit_err, out_2bit_err}), 32'd0);
        check("rst_cnt_1bit",  32'(cnt_1bit),     32'd0);
        check("rst_cnt_2bit",  32'(cnt_2bit),     32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        send(0, 1'b1); drain();
        check("clean_cnt_1bit", 32'(cnt_1bit), 32'd0);
        check("clean_cnt_2bit", 32'(cnt_2bit), 32'd0);
        send(1, 1'b1); drain();
        check("corr_data_cnt_1bit", 32'(cnt_1bit), 32'd1);
        send(2, 1'b1); drain();
        check("corr_par_cnt_1bit", 32'(cnt_1bit), 32'd2);

        send(3, 1'b1); send(4, 1'b1); drain();
        check("uncorr_cnt_2bit", 32'(cnt_2bit), 32'd2);
        check("uncorr_cnt_1bit", 32'(cnt_1bit), 32'd2);
`ifdef SECDED_ERR_LOG_EN
        check("log_valid", 32'(err_log_valid),    32'd1);
        check("log_code",  32'(err_log_code),     32'h0028);
        check("log_syn",   32'(err_log_syndrome), 32'd6);
`endif

        send(5, 1'b1); send(6, 1'b1); send(7, 1'b1); send(8, 1'b1); drain();
        check("sat_cnt_1bit", 32'(cnt_1bit), 32'd3);
        check("sat_cnt_2bit", 32'(cnt_2bit), 32'd2);

        send(1, 1'b1);
        lat = -1;
        for (int i = 0; i < 10 && lat < 0; i++) begin
            @(negedge clock);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                lat = i;
                cnt_clear = 1'b1;
            end
        end
        check("latency_negedges", 32'(lat), 32'd1);
        idle(1'b1);
        idle(1'b1);
        #3;
        check("clr_inc_cnt_1bit", 32'(cnt_1bit), 32'd1);
        check("clr_cnt_2bit",     32'(cnt_2bit), 32'd0);
`ifdef SECDED_ERR_LOG_EN
        check("clr_log_valid", 32'(err_log_valid), 32'd0);
`endif
        send(4, 1'b1); drain();
        check("after_clr_cnt_2bit", 32'(cnt_2bit), 32'd1);
        send(3, 1'b1); drain();
`ifdef SECDED_ERR_LOG_EN
        check("sticky_log_valid", 32'(err_log_valid),    32'd1);
        check("sticky_log_code",  32'(err_log_code),     32'h0112);
        check("sticky_log_syn",   32'(err_log_syndrome), 32'hD);
`endif

        k = 0;
        for (int c = 1; c <= 40 && k < 6; c++) begin
            @(negedge clock);
            in_valid  = 1'b1;
            in_code   = vecs[bp_seq[k]].code;
            out_ready = !(c >= 3 && c <= 7);
            cnt_clear = 1'b0;
            #1;
            if (c == 2) check("bp_in_ready_open",  32'(in_ready), 32'd1);
            if (c == 5) check("bp_in_ready_stall", 32'(in_ready), 32'd0);
            if (in_ready) begin
                sb.push_back(vecs[bp_seq[k]]);
                k++;
            end
        end
        if (k < 6) fail_now("bp_stream_timeout");
        drain();
        check("bp_cnt_1bit", 32'(cnt_1bit), 32'd3);
        check("bp_cnt_2bit", 32'(cnt_2bit), 32'd3);

        send(5, 1'b0);
        send(6, 1'b0);
        @(posedge clock);
        #3;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        sb.delete();
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_code",  32'(out_code),  32'd0);
        check("arst_cnt_1bit",  32'(cnt_1bit),  32'd0);
        check("arst_cnt_2bit",  32'(cnt_2bit),  32'd0);
`ifdef SECDED_ERR_LOG_EN
        check("arst_log_valid", 32'(err_log_valid), 32'd0);
        check("arst_log_code",  32'(err_log_code),  32'd0);
`endif
        @(negedge clock);
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        #1;
        check("arst_rel_in_ready",  32'(in_ready),  32'd1);
        check("arst_rel_out_valid", 32'(out_valid), 32'd0);
        send(5, 1'b1); drain();
        check("final_cnt_1bit", 32'(cnt_1bit), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/secded_pipe_decoder.md
Name: secded_pipe_decoder

Overview:
- Parametrised, pipelined successor to the team's fixed (13,8) SECDED decoder.
- Decodes extended-Hamming codewords for any DATA_W, corrects single-bit errors, flags double and uncorrectable errors, and extracts the data field.
- Sits on a valid/ready stream between memory read-out and the consumer; throughput 1 word/cycle.
- Keeps saturating error counters for software scrub/health reporting.

Parameters:
- DATA_W, 8: data bits per word.
- P, derived (not overridable): smallest P with 2**P >= DATA_W+P+1. Equals 4 for DATA_W=8.
- CW, derived: DATA_W+P+1. Equals 13 for DATA_W=8.
- CNT_W, 16: error counter width.

Ports:
- clock, input, 1: sole clock.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: input codeword valid.
- in_ready, output, 1: decoder accepts in_code this cycle.
- in_code, input, CW: received codeword.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts result.
- out_code, output, CW: corrected codeword.
- out_data, output, DATA_W: extracted (corrected) data.
- out_syndrome, output, P: raw Hamming syndrome.
- out_1bit_err, output, 1: single error, corrected.
- out_2bit_err, output, 1: uncorrectable error.
- cnt_clear, input, 1: synchronous clear of both counters.
- cnt_1bit, output, CNT_W: count of corrected words, saturating.
- cnt_2bit, output, CNT_W: count of uncorrectable words, saturating.

Behaviour:
- Codeword layout:
  - bit 0 is overall even parity;
  - bits at positions 2**k (1,2,4,…) are Hamming parity;
  - the remaining positions 1..CW-1, ascending, carry data[0..DATA_W-1]. For DATA_W=8: positions 3,5,6,7,9,10,11,12.
- Syndrome: bit k = XOR of in_code[i] over all i in 1..CW-1 with bit k of i set. pfail = XOR of all CW bits.
- Classification:
  - pfail=0, syn=0: clean; both flags 0; out_code = in_code.
  - pfail=1, syn=0: out_1bit_err=1; flip bit 0.
  - pfail=1, 0<syn<CW: out_1bit_err=1; flip bit syn.
  - pfail=1, syn>=CW: out_2bit_err=1; no flip. This case is an invalid position and therefore a multi-bit error.
  - pfail=0, syn!=0: out_2bit_err=1; no flip. out_code = in_code.
  - The two flags are never both 1.
- Pipeline:
  - Stage 1 registers in_code, syndrome and pfail.
  - Stage 2 registers the corrected code, data, flags and syndrome.
  - Latency is 2 cycles from the in_valid&&in_ready edge to out_valid.
- Handshake:
  - A stage advances when it is empty or the stage downstream advances. in_ready = !s1_valid || s1_advance.
  - Full throughput under continuous out_ready=1, with no bubbles.
  - While out_valid && !out_ready, all out_* signals hold stable.
  - in_ready falls only once both stages are full.
  - No combinational path from in_valid to out_valid. in_ready may depend combinationally on out_ready.
- Counters:
  - Increment only on an output transfer (out_valid && out_ready) carrying the respective flag.
  - Saturate at all-ones.
  - cnt_clear with a same-cycle increment: counter loads 1. cnt_clear alone: loads 0.
- Reset (asynchronous):
  - Stage valids = 0, out_valid = 0, in_ready = 1 on the first cycle after release.
  - out_code, out_data, out_syndrome = 0; both flags = 0; both counters = 0.
  - Reset mid-stream drops in-flight words silently.

Optional Feature:
- Macro: SECDED_ERR_LOG_EN.
- Enabled:
  - Adds outputs err_log_valid (1), err_log_code (CW) and err_log_syndrome (P).
  - These capture out_code and out_syndrome of the first uncorrectable word transferred since reset or cnt_clear.
  - Sticky: later errors do not overwrite the log.
  - cnt_clear clears err_log_valid. If an uncorrectable transfer happens in the same cycle as cnt_clear, that word is logged.
  - Reset clears all log outputs to 0.
- Disabled: these ports and registers do not exist.

Decomposition:
- Package secded_pkg:
  - function calc_p(DATA_W);
  - function is_pow2(idx);
  - function extract_data (codeword to data);
  - typedef of the classification enum {CLEAN, CORR, UNCORR}.
- One sub-module, secded_syndrome_calc: combinational, parametrised by CW and P; produces syndrome and pfail. Instantiated in stage 1.

Test Plan (DATA_W=8):
- Clean word: in_code=13'h0000 -> 2 cycles later out_code=0, out_data=0, syn=0, both flags 0; counters unchanged.
- Single data-bit error: in_code=13'h0020 -> syn=5, out_1bit_err=1, out_code=13'h0000; cnt_1bit=1. Then in_code=13'h0001 -> syn=0, out_1bit_err=1, out_code=0; cnt_1bit=2.
- Double error: in_code=13'h0028 -> syn=6, out_2bit_err=1, out_code=13'h0028. Triple error 13'h0112 -> syn=13, pfail=1, out_2bit_err=1, no flip. cnt_2bit=2; log (if enabled) holds 13'h0028, syndrome 6.
- Back-pressure: stream 6 words with out_ready=0 for cycles 3-7 -> in_ready=0 once both stages are full; outputs stable; all 6 words delivered in order, none lost or duplicated.
- Saturation/clear: CNT_W=2, send 5 corrected words -> cnt_1bit stays 3. cnt_clear asserted with a corrected transfer in the same cycle -> cnt_1bit=1.
- Async reset asserted mid-stream between clock edges -> out_valid and counters are 0 immediately; in_ready=1 after release.
